// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM states, frame constants, timeout width.
package ps2_keyboard_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int TMO_W      = 10;
  localparam logic PAR_ODD  = 1'b1;

  // Odd parity: data bits plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return (^{d, p}) == PAR_ODD;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_line_filter.sv
// 2-flop synchronizers on PS/2 clock/data plus a stability filter on the clock.
// fall_o is a registered one-cycle pulse when the filtered clock goes 1->0.
module ps2_line_filter #(
  parameter int FILTER = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic fclk_o,
  output logic fall_o,
  output logic dat_o
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       fclk_q;
  logic       fall_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fclk_q     <= 1'b1;
      fall_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      fall_q     <= 1'b0;
      // Count consecutive cycles of disagreement; any agreement restarts it.
      if (clk_sync_q[1] != fclk_q) begin
        if (cnt_q == FILT_LAST) begin
          fclk_q <= clk_sync_q[1];
          fall_q <= fclk_q;
          cnt_q  <= 4'd0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= 4'd0;
      end
    end
  end

  assign fclk_o = fclk_q;
  assign fall_o = fall_q;
  assign dat_o  = dat_sync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard deframer: one-cycle rx_stb per byte, rx_err on bad frame/timeout.
// Define FPGA_ROBOTS_PS2_PARITY_EN to reject frames with bad odd parity.
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 340
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sixus_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic       hold_i,
  output logic       ps2_clk_oe_o,
  output logic [7:0] rx_dat_o,
  output logic       rx_stb_o,
  output logic       rx_err_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

  logic             fclk_unused;
  logic             fall;
  logic             dat;
  logic             edge_acc;
  logic             frame_ok;
  ps2_state_e       state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       sh_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       rx_dat_q;
  logic             rx_stb_q;
  logic             rx_err_q;
  logic             oe_q;

  ps2_line_filter #(.FILTER(FILTER)) u_filter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .fclk_o    (fclk_unused),
    .fall_o    (fall),
    .dat_o     (dat)
  );

  // Edges caused by our own clock drive are not from the keyboard.
  assign edge_acc = fall & ~oe_q;

`ifdef FPGA_ROBOTS_PS2_PARITY_EN
  logic par_q;
  assign frame_ok = odd_parity_ok(sh_q, par_q);
`else
  assign frame_ok = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      sh_q      <= 8'd0;
      tmo_q     <= '0;
      rx_dat_q  <= 8'd0;
      rx_stb_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      oe_q      <= 1'b0;
`ifdef FPGA_ROBOTS_PS2_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      oe_q     <= hold_i;
      rx_stb_q <= 1'b0;
      rx_err_q <= 1'b0;
      if (edge_acc) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (!dat) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            sh_q      <= {dat, sh_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef FPGA_ROBOTS_PS2_PARITY_EN
            par_q   <= dat;
`endif
            state_q <= ST_STOP;
          end
          default: begin
            if (dat && frame_ok) begin
              rx_dat_q <= sh_q;
              rx_stb_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        endcase
      end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
        rx_err_q <= 1'b1;
        state_q  <= ST_IDLE;
        tmo_q    <= '0;
      end else if (sixus_i && state_q != ST_IDLE) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign ps2_clk_oe_o = oe_q;
  assign rx_dat_o     = rx_dat_q;
  assign rx_stb_o     = rx_stb_q;
  assign rx_err_o     = rx_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; one system clock stands for ~1 us of PS/2 time.
module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sixus = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_dat = 1'b1;
  logic       hold = 1'b0;
  logic       ps2_clk_oe;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_err;
  wire        ps2_clk_pin = kb_clk & ~ps2_clk_oe;

  int cyc = 0;
  int div = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int stb_cyc = 0;
  int err_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] last_dat = 8'h00;
  int checks = 0;
  int passes = 0;

  ps2_keyboard_rx #(.FILTER(8), .TIMEOUT(340)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sixus_i      (sixus),
    .ps2_clk_i    (ps2_clk_pin),
    .ps2_dat_i    (kb_dat),
    .hold_i       (hold),
    .ps2_clk_oe_o (ps2_clk_oe),
    .rx_dat_o     (rx_dat),
    .rx_stb_o     (rx_stb),
    .rx_err_o     (rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    div   <= (div == 5) ? 0 : div + 1;
    sixus <= (div == 5);
  end

  always @(negedge clk) begin
    if (rx_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_cyc  <= cyc;
      last_dat <= rx_dat;
    end
    if (rx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (rx_stb && rx_err) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, ~(^d) ^ flip, d, 1'b0};
  endfunction

  // Bit 0 of f is the start bit; 80-cycle bit period, data changes while clock is high.
  task automatic send(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      kb_dat = f[i];
      tick(20);
      kb_clk = 1'b0;
      fall_cyc = cyc;
      tick(40);
      kb_clk = 1'b1;
      if (glitch) begin
        tick(8);
        kb_clk = 1'b0;
        tick(3);
        kb_clk = 1'b1;
        tick(9);
      end else begin
        tick(20);
      end
    end
    kb_dat = 1'b1;
    tick(20);
  endtask

  initial begin
    int s0, e0, d;
    tick(3);
    rst = 1'b0;
    check_eq("reset_rx_dat", 32'(rx_dat), 32'h00);
    check_eq("reset_rx_stb", 32'(rx_stb), 32'h0);
    check_eq("reset_rx_err", 32'(rx_err), 32'h0);
    check_eq("reset_clk_oe", 32'(ps2_clk_oe), 32'h0);
    tick(5);

    // 0x1C good frame, with stop-edge-to-strobe latency
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    check_eq("1c_stb_count", 32'(stb_cnt), 32'd1);
    check_eq("1c_err_count", 32'(err_cnt), 32'd0);
    check_eq("1c_data", 32'(last_dat), 32'h1C);
    check_eq("1c_latency", 32'(stb_cyc - fall_cyc), 32'd11);
    check_eq("1c_rx_dat_held", 32'(rx_dat), 32'h1C);

    // 0x5A with flipped parity
    s0 = stb_cnt; e0 = err_cnt;
    send(mk(8'h5A, 1'b1, 1'b1), 11, 1'b0);
`ifdef FPGA_ROBOTS_PS2_PARITY_EN
    check_eq("par_err_pulse", 32'(err_cnt - e0), 32'd1);
    check_eq("par_no_stb", 32'(stb_cnt - s0), 32'd0);
    check_eq("par_rx_dat_kept", 32'(rx_dat), 32'h1C);
`else
    check_eq("par_ignored_err", 32'(err_cnt - e0), 32'd0);
    check_eq("par_ignored_stb", 32'(stb_cnt - s0), 32'd1);
    check_eq("par_ignored_dat", 32'(rx_dat), 32'h5A);
`endif

    // partial frame then timeout, then 0xF0
    s0 = stb_cnt; e0 = err_cnt;
    send(mk(8'hF0, 1'b0, 1'b1), 5, 1'b0);
    tick(3000);
    check_eq("tmo_err_pulse", 32'(err_cnt - e0), 32'd1);
    d = err_cyc - fall_cyc;
    check_eq("tmo_latency_2ms", 32'(d >= 2040 && d <= 2060), 32'd1);
    check_eq("tmo_no_stb", 32'(stb_cnt - s0), 32'd0);
    send(mk(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    check_eq("f0_stb", 32'(stb_cnt - s0), 32'd1);
    check_eq("f0_data", 32'(last_dat), 32'hF0);
    check_eq("f0_no_err", 32'(err_cnt - e0), 32'd1);

    // idle glitches with data low must not start a frame
    s0 = stb_cnt; e0 = err_cnt;
    kb_dat = 1'b0;
    for (int g = 0; g < 4; g++) begin
      kb_clk = 1'b0;
      tick(3);
      kb_clk = 1'b1;
      tick(20);
    end
    kb_dat = 1'b1;
    tick(2500);
    check_eq("glitch_idle_no_err", 32'(err_cnt - e0), 32'd0);
    send(mk(8'h29, 1'b0, 1'b1), 11, 1'b1);
    check_eq("glitch_29_stb", 32'(stb_cnt - s0), 32'd1);
    check_eq("glitch_29_data", 32'(last_dat), 32'h29);
    check_eq("glitch_29_no_err", 32'(err_cnt - e0), 32'd0);

    // reset mid-frame
    s0 = stb_cnt; e0 = err_cnt;
    send(mk(8'h77, 1'b0, 1'b1), 5, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2500);
    check_eq("rst_abort_no_err", 32'(err_cnt - e0), 32'd0);
    check_eq("rst_abort_no_stb", 32'(stb_cnt - s0), 32'd0);
    send(mk(8'h12, 1'b0, 1'b1), 11, 1'b0);
    check_eq("rst_12_stb", 32'(stb_cnt - s0), 32'd1);
    check_eq("rst_12_data", 32'(last_dat), 32'h12);

    // hold inhibits the device
    s0 = stb_cnt; e0 = err_cnt;
    hold = 1'b1;
    check_eq("hold_oe_not_yet", 32'(ps2_clk_oe), 32'd0);
    tick(1);
    check_eq("hold_oe_next_cycle", 32'(ps2_clk_oe), 32'd1);
    send(mk(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    hold = 1'b0;
    tick(2500);
    check_eq("hold_no_stb", 32'(stb_cnt - s0), 32'd0);
    check_eq("hold_no_err", 32'(err_cnt - e0), 32'd0);
    check_eq("hold_oe_released", 32'(ps2_clk_oe), 32'd0);

    // bad stop bit
    s0 = stb_cnt; e0 = err_cnt;
    send(mk(8'h1C, 1'b0, 1'b0), 11, 1'b0);
    check_eq("stop0_err", 32'(err_cnt - e0), 32'd1);
    check_eq("stop0_no_stb", 32'(stb_cnt - s0), 32'd0);
    check_eq("stop0_latency", 32'(err_cyc - fall_cyc), 32'd11);

    check_eq("stb_err_exclusive", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receive-only PS/2 keyboard front end for the robots game. It samples the raw PS/2 port A clock and data lines, deframes 11-bit device-to-host frames, and delivers each scan-code byte as a one-cycle strobe. Its outputs fill the PS/2 byte input of the game's control block, currently tied to zero. A hold input lets the consumer inhibit the keyboard by pulling the PS/2 clock low.

## Interface
- `FILTER`, default 8: clk cycles PS/2 clock must be stable before a level change is accepted (1..15).
- `TIMEOUT`, default 340: `sixus` ticks with no accepted falling edge before a partial frame is discarded (~2 ms).

Ports:
- `clk` in 1: ~65 MHz system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `sixus` in 1: one-cycle pulse every ~6 µs, from the clock module.
- `ps2_clk_in` in 1: raw PS/2 clock pin level (asynchronous).
- `ps2_dat_in` in 1: raw PS/2 data pin level (asynchronous).
- `hold` in 1: consumer request to inhibit the device.
- `ps2_clk_oe` out 1: 1 = drive PS/2 clock pin low (open drain); top level tristates otherwise.
- `rx_dat` out 8: last received byte; valid when `rx_stb`=1, held until the next strobe.
- `rx_stb` out 1: one-cycle pulse, new byte.
- `rx_err` out 1: one-cycle pulse, frame rejected (framing, parity, timeout).

## Operation
- Both pins pass through a 2-flop synchronizer. The clock line then passes a stability filter: the filtered level `fclk` takes the synced level only after the synced level has differed from `fclk` for `FILTER` consecutive cycles. The data line is synchronized only.
- A falling edge is `fclk` going 1->0. The data bit is sampled on the same cycle from the synced data line.
- State machine states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 is ignored; stay in IDLE with no error.
  - DATA: shift each bit into a shift register, LSB first. After bit 7, go to PARITY.
  - PARITY: latch the bit and go to STOP.
  - STOP: if the stop bit is 1 and the parity is good, load `rx_dat` and pulse `rx_stb`. Otherwise pulse `rx_err`. Go to IDLE in either case.
- Timeout: a 10-bit counter clears on every falling edge and increments on `sixus` when not in IDLE. When it reaches `TIMEOUT`: pulse `rx_err`, go to IDLE, discard the partial byte.
- `ps2_clk_oe` = registered `hold`.
  - If `hold` rises mid-frame, the frame normally ends by timeout with `rx_err`, and the keyboard retransmits.
  - Edges produced by our own clock drive are ignored while `ps2_clk_oe`=1, and the state machine stays in IDLE.
- Simultaneous events: if `sixus` and an accepted edge occur in the same cycle, the edge wins and the counter clears.
- Reset values: `rx_dat`=0, `rx_stb`=0, `rx_err`=0, `ps2_clk_oe`=0, state IDLE, synchronizers and `fclk`=1, counters 0.
  - Reset mid-frame abandons the frame with no strobe and no error.

## Timing
- Pin edge to accepted edge: 2 (sync) + `FILTER` cycles.
- `rx_stb`/`rx_err` assert on the cycle after the stop-bit edge is accepted: 3+`FILTER` cycles after the pin edge.
- `rx_dat` changes in the same cycle `rx_stb` asserts.
- `hold` to `ps2_clk_oe`: 1 cycle.
- `rx_stb` and `rx_err` are never both high in the same cycle.
- There is no backpressure. The consumer must accept a byte in the strobe cycle. Minimum byte spacing is ~660 µs at the PS/2 rate.

## Configuration
- Macro: `FPGA_ROBOTS_PS2_PARITY_EN`.
  - Defined: parity must be odd over the 8 data bits plus the parity bit. A mismatch gives `rx_err` and no `rx_stb`.
  - Undefined: the parity bit is sampled and ignored. Only a bad stop bit or a timeout causes `rx_err`.

## Structure
- Shared package/include: state encodings (IDLE, DATA, PARITY, STOP), frame constants (8 data bits, odd parity), timeout counter width (10).
- One natural sub-module, `ps2_line_filter`: 2-flop synchronizer plus `FILTER` stability counter. It outputs `fclk` and a falling-edge pulse.

## Test plan
- Frame for 0x1C (start 0, bits 0011_1000 LSB first, parity 0, stop 1), 80 µs PS/2 clock period -> exactly one `rx_stb` with `rx_dat`=0x1C, `rx_err` never high.
- 0x5A sent with parity flipped -> with `FPGA_ROBOTS_PS2_PARITY_EN`: `rx_err` pulse, no `rx_stb`, `rx_dat` unchanged. Without it: `rx_stb` with 0x5A.
- 5 bits of a frame, then 3 ms idle, then a full 0xF0 frame -> one `rx_err` at ~2 ms, then `rx_stb` with 0xF0 only.
- 3-cycle low glitches on the clock line during IDLE and between bits, with `FILTER`=8 -> no state change; a subsequent 0x29 frame is received correctly.
- `rst` asserted for one cycle after bit 4, then a full 0x12 frame -> no strobe or error from the aborted frame; one `rx_stb` with 0x12.
- `hold`=1 -> `ps2_clk_oe`=1 on the next cycle and no frame activity. Stop bit = 0 on a 0x1C frame -> `rx_err` pulse, no `rx_stb`.
